logic_unit_n_bits: RTL and testbench

- Registered, parametrised bitwise logic unit for the ALU datapath; next generation of the plain N-bit OR block.
- Performs AND/OR/XOR/NAND/NOR/XNOR on two Width-bit operands with one-cycle latency.
- Adds multi-beat accumulate modes (OR/XOR reduction across a burst), valid/ready flow control, zero flag and beat counter.

---
 rtl/logic_unit_pkg.sv | 23 ++
 rtl/logic_unit_comb.sv | 29 ++
 rtl/logic_unit_n_bits.sv | 144 ++++++++++++++
 tb/tb_logic_unit_n_bits.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/logic_unit_pkg.sv
// rtl/logic_unit_pkg.sv - op codes, FSM state encoding and counter helper for logic_unit_n_bits
package logic_unit_pkg;

   localparam logic [2:0] OP_AND     = 3'b000;
   localparam logic [2:0] OP_OR      = 3'b001;
   localparam logic [2:0] OP_XOR     = 3'b010;
   localparam logic [2:0] OP_NAND    = 3'b011;
   localparam logic [2:0] OP_NOR     = 3'b100;
   localparam logic [2:0] OP_XNOR    = 3'b101;
   localparam logic [2:0] OP_ACC_OR  = 3'b110;
   localparam logic [2:0] OP_ACC_XOR = 3'b111;

   typedef enum logic {
      IDLE  = 1'b0,
      ACCUM = 1'b1
   } state_e;

   // All-ones value of a w-bit saturating counter
   function automatic longint unsigned cnt_max_f(input int unsigned w);
      return (64'd1 << w) - 64'd1;
   endfunction

endpackage

// File: rtl/logic_unit_comb.sv
// rtl/logic_unit_comb.sv - combinational bitwise function f(op, first, second)
module logic_unit_comb
   import logic_unit_pkg::*;
#(
   parameter int Width = 4
) (
   input  logic [2:0]       op_i,
   input  logic [Width-1:0] first_i,
   input  logic [Width-1:0] second_i,
   output logic [Width-1:0] result_o
);

   // Accumulate ops reduce the operand pair with their own OR/XOR before folding into the accumulator
   always_comb begin
      result_o = '0;
      case (op_i)
         OP_AND:     result_o = first_i & second_i;
         OP_OR:      result_o = first_i | second_i;
         OP_XOR:     result_o = first_i ^ second_i;
         OP_NAND:    result_o = ~(first_i & second_i);
         OP_NOR:     result_o = ~(first_i | second_i);
         OP_XNOR:    result_o = ~(first_i ^ second_i);
         OP_ACC_OR:  result_o = first_i | second_i;
         OP_ACC_XOR: result_o = first_i ^ second_i;
         default:    result_o = '0;
      endcase
   end

endmodule

// File: rtl/logic_unit_n_bits.sv
// rtl/logic_unit_n_bits.sv - registered logic unit with burst accumulate, handshake, zero flag and beat count (optional Parity via ALU_LOGIC_PARITY_EN)
module logic_unit_n_bits
   import logic_unit_pkg::*;
#(
   parameter int Width    = 4,
   parameter int CntWidth = 3
) (
   input  logic                clock_i,
   input  logic                reset_n_i,
   input  logic                in_valid_i,
   output logic                in_ready_o,
   input  logic [Width-1:0]    first_i,
   input  logic [Width-1:0]    second_i,
   input  logic [2:0]          op_i,
   input  logic                last_i,
   output logic                out_valid_o,
   input  logic                out_ready_i,
   output logic [Width-1:0]    output_o,
   output logic                zero_o,
`ifdef ALU_LOGIC_PARITY_EN
   output logic                parity_o,
`endif
   output logic [CntWidth-1:0] count_o
);

   localparam logic [CntWidth-1:0] CntMax = CntWidth'(cnt_max_f(CntWidth));
   localparam logic [CntWidth-1:0] CntOne = CntWidth'(1);

   state_e              state_q, state_d;
   logic [2:0]          op_q, op_d;
   logic [Width-1:0]    acc_q, acc_d;
   logic [CntWidth-1:0] cnt_q, cnt_d;
   logic                out_valid_q, out_valid_d;
   logic [Width-1:0]    output_q, output_d;
   logic                zero_q, zero_d;
   logic [CntWidth-1:0] count_q, count_d;

   logic                in_xfer, out_xfer;
   logic [2:0]          op_eff;
   logic                is_acc;
   logic [Width-1:0]    pair_res;
   logic [Width-1:0]    acc_base, acc_new;
   logic [CntWidth-1:0] cnt_new;

   assign in_ready_o = reset_n_i & (~out_valid_q | out_ready_i);
   assign in_xfer    = in_valid_i & in_ready_o;
   assign out_xfer   = out_valid_q & out_ready_i;

   // Inside a burst the latched op wins; the op input only matters in IDLE
   assign op_eff = (state_q == ACCUM) ? op_q : op_i;
   assign is_acc = (op_eff == OP_ACC_OR) || (op_eff == OP_ACC_XOR);

   logic_unit_comb #(.Width(Width)) u_comb (
      .op_i     (op_eff),
      .first_i  (first_i),
      .second_i (second_i),
      .result_o (pair_res)
   );

   // A fresh burst folds into zero, so the first beat's accumulator is just the pair result
   assign acc_base = (state_q == ACCUM) ? acc_q : '0;
   assign acc_new  = (op_eff == OP_ACC_XOR) ? (acc_base ^ pair_res) : (acc_base | pair_res);
   assign cnt_new  = (state_q == ACCUM) ? ((cnt_q == CntMax) ? cnt_q : cnt_q + CntOne) : CntOne;

   // Next-state: load a result on result-producing beats, otherwise drop valid on drain
   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      out_valid_d = out_valid_q;
      output_d    = output_q;
      zero_d      = zero_q;
      count_d     = count_q;
      if (in_xfer && !is_acc) begin
         out_valid_d = 1'b1;
         output_d    = pair_res;
         zero_d      = (pair_res == '0);
         count_d     = CntOne;
      end else if (in_xfer && last_i) begin
         out_valid_d = 1'b1;
         output_d    = acc_new;
         zero_d      = (acc_new == '0);
         count_d     = cnt_new;
         state_d     = IDLE;
         acc_d       = '0;
         cnt_d       = '0;
      end else if (in_xfer) begin
         state_d = ACCUM;
         op_d    = op_eff;
         acc_d   = acc_new;
         cnt_d   = cnt_new;
         if (out_xfer) begin
            out_valid_d = 1'b0;
         end
      end else if (out_xfer) begin
         out_valid_d = 1'b0;
      end
   end

   // FSM and all registered state; reset discards any burst in flight
   always_ff @(posedge clock_i) begin
      if (!reset_n_i) begin
         state_q     <= IDLE;
         op_q        <= OP_AND;
         acc_q       <= '0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         output_q    <= '0;
         zero_q      <= 1'b0;
         count_q     <= '0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         output_q    <= output_d;
         zero_q      <= zero_d;
         count_q     <= count_d;
      end
   end

`ifdef ALU_LOGIC_PARITY_EN
   logic parity_q;

   // Parity tracks whatever the output register will hold next
   always_ff @(posedge clock_i) begin
      if (!reset_n_i) begin
         parity_q <= 1'b0;
      end else begin
         parity_q <= ^output_d;
      end
   end

   assign parity_o = parity_q;
`endif

   assign out_valid_o = out_valid_q;
   assign output_o    = output_q;
   assign zero_o      = zero_q;
   assign count_o     = count_q;

endmodule

// File: tb/tb_logic_unit_n_bits.sv
// tb/tb_logic_unit_n_bits.sv - directed table-driven bench for logic_unit_n_bits
module tb_logic_unit_n_bits;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] first;
   logic [3:0] second;
   logic [2:0] op;
   logic       last;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] result;
   logic       zero;
   logic [2:0] count;
`ifdef ALU_LOGIC_PARITY_EN
   logic       parity;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   logic_unit_n_bits #(.Width(4), .CntWidth(3)) dut (
      .clock_i     (clk),
      .reset_n_i   (reset_n),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .first_i     (first),
      .second_i    (second),
      .op_i        (op),
      .last_i      (last),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .output_o    (result),
      .zero_o      (zero),
`ifdef ALU_LOGIC_PARITY_EN
      .parity_o    (parity),
`endif
      .count_o     (count)
   );

   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
      logic [2:0] op;
      logic       last;
      logic [3:0] exp_out;
      logic       exp_zero;
   } vec_t;

   vec_t vecs[12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic [3:0] a, input logic [3:0] b, input logic [2:0] o, input logic l);
      in_valid = 1'b1;
      first    = a;
      second   = b;
      op       = o;
      last     = l;
      step();
      in_valid = 1'b0;
   endtask

   initial begin
      vecs[0]  = '{4'b1100, 4'b1010, 3'b000, 1'b0, 4'b1000, 1'b0};
      vecs[1]  = '{4'b1010, 4'b0101, 3'b001, 1'b0, 4'b1111, 1'b0};
      vecs[2]  = '{4'b1010, 4'b0110, 3'b010, 1'b0, 4'b1100, 1'b0};
      vecs[3]  = '{4'b1111, 4'b1111, 3'b011, 1'b0, 4'b0000, 1'b1};
      vecs[4]  = '{4'b0000, 4'b0000, 3'b100, 1'b0, 4'b1111, 1'b0};
      vecs[5]  = '{4'b1010, 4'b0100, 3'b100, 1'b0, 4'b0001, 1'b0};
      vecs[6]  = '{4'b1010, 4'b1010, 3'b101, 1'b0, 4'b1111, 1'b0};
      vecs[7]  = '{4'b1100, 4'b1010, 3'b101, 1'b0, 4'b1001, 1'b0};
      vecs[8]  = '{4'b0101, 4'b0101, 3'b010, 1'b0, 4'b0000, 1'b1};
      vecs[9]  = '{4'b0011, 4'b0100, 3'b110, 1'b1, 4'b0111, 1'b0};
      vecs[10] = '{4'b0110, 4'b0011, 3'b111, 1'b1, 4'b0101, 1'b0};
      vecs[11] = '{4'b1111, 4'b0011, 3'b000, 1'b1, 4'b0011, 1'b0};

      reset_n   = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      first     = '0;
      second    = '0;
      op        = '0;
      last      = 1'b0;
      step();
      step();
      chk("reset_out_valid", 32'(out_valid), 0);
      chk("reset_output", 32'(result), 0);
      chk("reset_zero", 32'(zero), 0);
      chk("reset_count", 32'(count), 0);
      chk("reset_in_ready", 32'(in_ready), 0);
      reset_n = 1'b1;
      #1;
      chk("idle_in_ready", 32'(in_ready), 1);

      // Back-to-back single-beat ops: every cycle produces a result
      for (int i = 0; i < 12; i++) begin
         chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 1);
         in_valid = 1'b1;
         first    = vecs[i].a;
         second   = vecs[i].b;
         op       = vecs[i].op;
         last     = vecs[i].last;
         step();
         chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 1);
         chk($sformatf("vec%0d_output", i), 32'(result), 32'(vecs[i].exp_out));
         chk($sformatf("vec%0d_zero", i), 32'(zero), 32'(vecs[i].exp_zero));
         chk($sformatf("vec%0d_count", i), 32'(count), 1);
      end
      in_valid = 1'b0;
      step();
      chk("drain_out_valid", 32'(out_valid), 0);
      chk("drain_output_held", 32'(result), 32'(4'b0011));

      // ACC_OR burst; op input on later beats must be ignored
      beat(4'b0001, 4'b0000, 3'b110, 1'b0);
      chk("accor_b1_out_valid", 32'(out_valid), 0);
      beat(4'b0010, 4'b0000, 3'b000, 1'b0);
      chk("accor_b2_out_valid", 32'(out_valid), 0);
      beat(4'b1000, 4'b0000, 3'b000, 1'b1);
      chk("accor_out_valid", 32'(out_valid), 1);
      chk("accor_output", 32'(result), 32'(4'b1011));
      chk("accor_count", 32'(count), 3);
      chk("accor_zero", 32'(zero), 0);
      beat(4'b1100, 4'b0110, 3'b000, 1'b0);
      chk("post_burst_idle_output", 32'(result), 32'(4'b0100));
      chk("post_burst_idle_count", 32'(count), 1);
      step();

      // Backpressure: result held, nothing accepted
      out_ready = 1'b0;
      beat(4'b0011, 4'b0000, 3'b001, 1'b0);
      chk("bp_out_valid", 32'(out_valid), 1);
      in_valid = 1'b1;
      first    = 4'b1111;
      second   = 4'b0000;
      op       = 3'b010;
      last     = 1'b0;
      for (int c = 0; c < 4; c++) begin
         chk($sformatf("bp%0d_in_ready", c), 32'(in_ready), 0);
         step();
         chk($sformatf("bp%0d_out_valid", c), 32'(out_valid), 1);
         chk($sformatf("bp%0d_output", c), 32'(result), 32'(4'b0011));
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      #1;
      chk("bp_release_in_ready", 32'(in_ready), 1);
      step();
      chk("bp_drained_out_valid", 32'(out_valid), 0);
      chk("bp_drained_output", 32'(result), 32'(4'b0011));

      // Saturating count on a 9-beat ACC_XOR burst
      for (int k = 0; k < 9; k++) begin
         beat(4'b0001, 4'b0000, 3'b111, (k == 8));
         if (k < 8) chk($sformatf("sat_b%0d_out_valid", k), 32'(out_valid), 0);
      end
      chk("sat_out_valid", 32'(out_valid), 1);
      chk("sat_output", 32'(result), 32'(4'b0001));
      chk("sat_count", 32'(count), 7);
      step();

      // Reset in the middle of a burst
      beat(4'b0100, 4'b0000, 3'b110, 1'b0);
      beat(4'b0100, 4'b0000, 3'b110, 1'b0);
      reset_n = 1'b0;
      #1;
      chk("rst_mid_in_ready", 32'(in_ready), 0);
      step();
      chk("rst_mid_out_valid", 32'(out_valid), 0);
      chk("rst_mid_output", 32'(result), 0);
      chk("rst_mid_count", 32'(count), 0);
      chk("rst_mid_zero", 32'(zero), 0);
      reset_n = 1'b1;
      beat(4'b1100, 4'b1010, 3'b000, 1'b0);
      chk("rst_and_out_valid", 32'(out_valid), 1);
      chk("rst_and_output", 32'(result), 32'(4'b1000));
      chk("rst_and_count", 32'(count), 1);
      beat(4'b0001, 4'b0000, 3'b110, 1'b1);
      chk("rst_acc_output", 32'(result), 32'(4'b0001));
      chk("rst_acc_count", 32'(count), 1);
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
